// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: operand forwarding, load-use and
// branch stall detection, and a sequencer that freezes F/D/E during a divide.

module hazard_fwd (
    input  logic [4:0] srcD,
    input  logic [4:0] srcE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteM,
    input  logic       regwriteW,
    output logic       fwdD,
    output logic [1:0] fwdE
);
    logic hitM, hitW;

    // $0 is hard-wired zero, so a write to it must never be forwarded.
    assign hitM = regwriteM && (srcE != 5'd0) && (writeregM == srcE);
    assign hitW = regwriteW && (srcE != 5'd0) && (writeregW == srcE);
    assign fwdE = hitM ? 2'b10 : (hitW ? 2'b01 : 2'b00);
    assign fwdD = regwriteM && (srcD != 5'd0) && (writeregM == srcD);
endmodule

module hazard_unit #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       divE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushE,
    output logic       forwardaD,
    output logic       forwardbD,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       div_busy,
    output logic       div_ready
);
    localparam int NUM_SRC = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [NUM_SRC-1:0][4:0] srcD, srcE;
    logic [NUM_SRC-1:0]      fwdD;
    logic [NUM_SRC-1:0][1:0] fwdE;

    // Operand 0 is rs, operand 1 is rt.
    assign srcD = {rtD, rsD};
    assign srcE = {rtE, rsE};

    for (genvar g = 0; g < NUM_SRC; g++) begin : gFwd
        hazard_fwd uFwd (
            .srcD      (srcD[g]),
            .srcE      (srcE[g]),
            .writeregM (writeregM),
            .writeregW (writeregW),
            .regwriteM (regwriteM),
            .regwriteW (regwriteW),
            .fwdD      (fwdD[g]),
            .fwdE      (fwdE[g])
        );
    end

    assign forwardaD = fwdD[0];
    assign forwardbD = fwdD[1];
    assign forwardaE = fwdE[0];
    assign forwardbE = fwdE[1];

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             useE, useM, lwstall, branchstall, divstall;

    // Register $0 still counts here; stalling on it is harmless and simpler.
    assign useE        = (writeregE == rsD) || (writeregE == rtD);
    assign useM        = (writeregM == rsD) || (writeregM == rtD);
    assign lwstall     = memtoregE && useE;
    assign branchstall = branchD && ((regwriteE && useE) || (memtoregM && useM));
    assign divstall    = ((state == IDLE) && divE) || (state == BUSY);

    assign stallF    = lwstall || branchstall || divstall;
    assign stallD    = stallF;
    assign stallE    = divstall;
    // A frozen E must keep its divide, so no bubble while the divide stalls.
    assign flushE    = (lwstall || branchstall) && !divstall;
    assign div_busy  = (state == BUSY);
    assign div_ready = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (divE) begin
                    state <= BUSY;
                    cnt   <= CNT_W'(DIV_CYCLES - 1);
                end
                BUSY: if (cnt == CNT_W'(1)) begin
                    state <= DONE;
                    cnt   <= '0;
                end else begin
                    cnt   <= cnt - CNT_W'(1);
                end
                // divE is still high as the divide leaves E; DONE ignores it.
                DONE: state <= IDLE;
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule
